// File: rtl/rob_pkg.sv
// Shared types and helpers for the tagged read reorder buffer.
package rob_pkg;

    typedef logic [1:0] rresp_t;

    localparam rresp_t RESP_OKAY   = 2'b00;
    localparam rresp_t RESP_SLVERR = 2'b10;

    function automatic int tag_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rob_slot_ram.sv
// Per-slot payload storage: the upstream id is written on AR accept, and data/resp are written on R return.
module rob_slot_ram
    import rob_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  ID_WIDTH   = 4,
    parameter int  DEPTH      = 8,
    localparam int TAG_W      = tag_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  id_we,
    input  logic [TAG_W-1:0]      id_tag,
    input  logic [ID_WIDTH-1:0]   id_in,
    input  logic                  r_we,
    input  logic [TAG_W-1:0]      r_tag,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            resp_in,
    input  logic [TAG_W-1:0]      rd_tag,
    output logic [ID_WIDTH-1:0]   id_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            resp_out
);

    logic [ID_WIDTH-1:0]   id_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    rresp_t                resp_mem [DEPTH];

    // NOTE: the payload arrays have no reset. A slot is never read before
    // alloc/done mark it valid, so clearing the arrays would gain nothing.
    always_ff @(posedge clk) begin
        if (id_we) id_mem[id_tag] <= id_in;
    end

    always_ff @(posedge clk) begin
        if (r_we) begin
            data_mem[r_tag] <= data_in;
            resp_mem[r_tag] <= resp_in;
        end
    end

    assign id_out   = id_mem[rd_tag];
    assign data_out = data_mem[rd_tag];
    assign resp_out = resp_mem[rd_tag];

endmodule

// File: rtl/rob_tagged_rd.sv
// Read reorder buffer: tags each AR with a free slot, and returns R beats upstream in AR-accept order.
module rob_tagged_rd
    import rob_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  ID_WIDTH   = 4,
    parameter int  DEPTH      = 8,
    localparam int TAG_W      = tag_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_arid_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [TAG_W-1:0]      m_arid_o,
    output logic                  m_arvalid_o,
    input  logic                  m_arready_i,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [1:0]            s_rresp_o,
    output logic [ID_WIDTH-1:0]   s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    input  logic [DATA_WIDTH-1:0] m_rdata_i,
    input  logic [1:0]            m_rresp_i,
    input  logic [TAG_W-1:0]      m_rid_i,
    input  logic                  m_rvalid_i,
    output logic                  m_rready_o,
    output logic [TAG_W:0]        count_o,
    output logic                  err_o
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(DEPTH);

    logic [TAG_W-1:0] wr_ptr;
    logic [TAG_W-1:0] rd_ptr;
    logic [TAG_W:0]   count;
    logic [DEPTH-1:0] alloc;
    logic [DEPTH-1:0] done;
    logic             err;
    logic             full;
    logic             ar_fire;
    logic             r_in_ok;
    logic             r_out_fire;

    assign full        = (count == FULL_COUNT);
    assign m_arvalid_o = s_arvalid_i & ~full;
    assign s_arready_o = m_arready_i & ~full;
    assign m_arid_o    = wr_ptr;
    assign ar_fire     = s_arvalid_i & m_arready_i & ~full;

    // Every downstream beat already owns a slot, so it is always accepted; strays are only flagged.
    assign m_rready_o  = 1'b1;
    assign r_in_ok     = m_rvalid_i & alloc[m_rid_i] & ~done[m_rid_i];

    assign s_rvalid_o  = alloc[rd_ptr] & done[rd_ptr];
    assign r_out_fire  = s_rvalid_o & s_rready_i;

    assign count_o     = count;
    assign err_o       = err;

    // NOTE: all state uses non-blocking assignments, so every update in this
    // block sees the values from before the edge. Alloc, write and retire never
    // touch the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            alloc  <= '0;
            done   <= '0;
            err    <= 1'b0;
        end else begin
            if (ar_fire) begin
                alloc[wr_ptr] <= 1'b1;
                done[wr_ptr]  <= 1'b0;
                wr_ptr        <= wr_ptr + TAG_W'(1);
            end
            if (r_in_ok) begin
                done[m_rid_i] <= 1'b1;
            end
            if (m_rvalid_i && !r_in_ok) begin
                err <= 1'b1;
            end
            if (r_out_fire) begin
                alloc[rd_ptr] <= 1'b0;
                done[rd_ptr]  <= 1'b0;
                rd_ptr        <= rd_ptr + TAG_W'(1);
            end
            case ({ar_fire, r_out_fire})
                2'b10:   count <= count + (TAG_W + 1)'(1);
                2'b01:   count <= count - (TAG_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    rob_slot_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .DEPTH      (DEPTH)
    ) u_slot_ram (
        .clk      (clk),
        .id_we    (ar_fire),
        .id_tag   (wr_ptr),
        .id_in    (s_arid_i),
        .r_we     (r_in_ok),
        .r_tag    (m_rid_i),
        .data_in  (m_rdata_i),
        .resp_in  (m_rresp_i),
        .rd_tag   (rd_ptr),
        .id_out   (s_rid_o),
        .data_out (s_rdata_o),
        .resp_out (s_rresp_o)
    );

endmodule
